// File: rtl/spi_top.sv
// SPI loopback: a master serializes a WIDTH-bit word onto an internal CS/SCLK/MOSI link and a slave reassembles it.
// Define SPI_TOP_MSB_FIRST_EN to transfer MSB first on the wire; LSB first otherwise.

module spi_master #(
  parameter int CLK_DIV = 10,
  parameter int WIDTH   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             newd,
  input  logic [WIDTH-1:0] din,
  output logic             sclk,
  output logic             tick,
  output logic             cs,
  output logic             mosi
);
  // state | meaning
  // IDLE  | cs high, waiting for newd at a rise tick
  // SEND  | cs low, one bit driven per rise tick
  typedef enum logic {IDLE, SEND} state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  logic [CW-1:0]    cnt;
  logic             rise_tick;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             cs_d, mosi_d;
  logic [WIDTH-1:0] sel;

  assign tick      = (cnt == CNT_MAX);
  assign rise_tick = tick & ~sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cs       <= cs_d;
      mosi     <= mosi_d;
    end
  end

`ifdef SPI_TOP_MSB_FIRST_EN
  assign sel = shreg_q << bitcnt_q;
`else
  assign sel = shreg_q >> bitcnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    cs_d     = cs;
    mosi_d   = mosi;
    if (rise_tick) begin
      case (state_q)
        IDLE: begin
          cs_d     = 1'b1;
          mosi_d   = 1'b0;
          bitcnt_d = '0;
          if (newd) begin
            shreg_d  = din;
            cs_d     = 1'b0;
`ifdef SPI_TOP_MSB_FIRST_EN
            mosi_d   = din[WIDTH-1];
`else
            mosi_d   = din[0];
`endif
            bitcnt_d = BW'(1);
            state_d  = SEND;
          end
        end
        SEND: begin
          if (bitcnt_q < BIT_LAST) begin
`ifdef SPI_TOP_MSB_FIRST_EN
            mosi_d = sel[WIDTH-1];
`else
            mosi_d = sel[0];
`endif
            bitcnt_d = bitcnt_q + 1'b1;
          end else begin
            cs_d     = 1'b1;
            mosi_d   = 1'b0;
            bitcnt_d = '0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

module spi_slave #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             tick,
  input  logic             cs,
  input  logic             mosi,
  output logic [WIDTH-1:0] dout,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] CNT_LAST = BW'(WIDTH - 1);

  logic [WIDTH-1:0] rx, rx_next;
  logic [BW-1:0]    count;
  logic             fall_tick;

  // divider wrap while sclk is high is the edge that drives sclk low
  assign fall_tick = tick & sclk;

`ifdef SPI_TOP_MSB_FIRST_EN
  assign rx_next = {rx[WIDTH-2:0], mosi};
`else
  assign rx_next = {mosi, rx[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx    <= '0;
      count <= '0;
      dout  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fall_tick) begin
        if (!cs) begin
          rx <= rx_next;
          if (count == CNT_LAST) begin
            dout  <= rx_next;
            done  <= 1'b1;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          count <= '0;
        end
      end
    end
  end
endmodule

module spi_top #(
  parameter int CLK_DIV = 10,
  parameter int WIDTH   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             newd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             done
);
  logic sclk, tick, cs, mosi;

  spi_master #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH)) s1 (
    .clk  (clk),
    .rst  (rst),
    .newd (newd),
    .din  (din),
    .sclk (sclk),
    .tick (tick),
    .cs   (cs),
    .mosi (mosi)
  );

  spi_slave #(.WIDTH(WIDTH)) s2 (
    .clk  (clk),
    .rst  (rst),
    .sclk (sclk),
    .tick (tick),
    .cs   (cs),
    .mosi (mosi),
    .dout (dout),
    .done (done)
  );
endmodule

// File: tb/tb_spi_top.sv
// Directed bench for spi_top: reset, single frame with wire order, random frames, extremes, held newd, mid-frame reset.

module tb_spi_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        newd = 1'b0;
  logic [11:0] din = '0;
  logic [11:0] dout;
  logic        done;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int accepts = 0;
  int accept_cyc = 0;
  int last_gap = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int nbits = 0;
  logic [11:0] mosi_seq = '0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;

  spi_top dut (
    .clk  (clk),
    .rst  (rst),
    .newd (newd),
    .din  (din),
    .dout (dout),
    .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (prev_cs && !dut.s1.cs) begin
      if (accepts > 0) last_gap = cyc - accept_cyc;
      accept_cyc = cyc;
      accepts++;
      mosi_seq = '0;
      nbits = 0;
    end
    if (prev_sclk && !dut.s1.sclk && !dut.s1.cs) begin
      mosi_seq = {mosi_seq[10:0], dut.s1.mosi};
      nbits++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_cs   = dut.s1.cs;
    prev_sclk = dut.s1.sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input string tag, input int target);
    int n = 0;
    while (accepts < target && n < 400) begin
      step();
      n++;
    end
    check(tag, (accepts >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_dones(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      step();
      n++;
    end
    check(tag, (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic start_frame(input logic [11:0] d);
    int a0 = accepts;
    din  = d;
    newd = 1'b1;
    wait_accepts("accept", a0 + 1);
    newd = 1'b0;
  endtask

  task automatic frame(input logic [11:0] d, input string tag);
    int d0 = done_cnt;
    start_frame(d);
    wait_dones({tag, "_done"}, d0 + 1);
    check({tag, "_latency"}, done_cyc - accept_cyc, 230);
    check({tag, "_dout"}, {20'd0, dout}, {20'd0, d});
  endtask

  initial begin
    int d0, a0, rel, t_rise, n;
    logic [11:0] d;

    // reset and free-running sclk
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_dout", {20'd0, dout}, 32'h000);
    check("rst_done", {31'd0, done}, 0);
    check("rst_cs", {31'd0, dut.s1.cs}, 1);
    check("rst_sclk", {31'd0, dut.s1.sclk}, 0);
    rst = 1'b1;
    rel = cyc;
    n = 0;
    while (!dut.s1.sclk && n < 50) begin @(negedge clk); n++; end
    t_rise = cyc;
    check("sclk_first_rise", t_rise - rel, 10);
    n = 0;
    while (dut.s1.sclk && n < 50) begin @(negedge clk); n++; end
    check("sclk_half_period", cyc - t_rise, 10);
    step();

    // single frame with wire order
    d0 = done_cnt;
    frame(12'hA5C, "single");
`ifdef SPI_TOP_MSB_FIRST_EN
    check("mosi_order", {20'd0, mosi_seq}, 32'hA5C);
`else
    check("mosi_order", {20'd0, mosi_seq}, 32'h3A5);
`endif
    check("mosi_bits", nbits, 12);
    repeat (40) step();
    check("single_one_pulse", done_cnt - d0, 1);

    // ten back-to-back random frames
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      d = 12'($urandom_range(0, 4095));
      frame(d, "rand");
    end
    check("rand_pulses", done_cnt - d0, 10);

    // extremes
    frame(12'h000, "zero");
    frame(12'hFFF, "ones");

    // newd held high, din changing mid-frame
    a0 = accepts;
    d0 = done_cnt;
    din  = 12'h3C1;
    newd = 1'b1;
    wait_accepts("held_acc1", a0 + 1);
    repeat (100) step();
    din = 12'h7E2;
    wait_dones("held_done1", d0 + 1);
    check("held_dout1", {20'd0, dout}, 32'h3C1);
    wait_accepts("held_acc2", a0 + 2);
    check("held_gap", last_gap, 260);
    repeat (100) step();
    din  = 12'h0F0;
    newd = 1'b0;
    wait_dones("held_done2", d0 + 2);
    check("held_dout2", {20'd0, dout}, 32'h7E2);
    repeat (300) step();
    check("held_no_extra", accepts - a0, 2);

    // reset mid-frame
    start_frame(12'h123);
    repeat (100) step();
    d0 = done_cnt;
    rst = 1'b0;
    repeat (3) step();
    check("mid_rst_dout", {20'd0, dout}, 32'h000);
    check("mid_rst_cs", {31'd0, dut.s1.cs}, 1);
    rst = 1'b1;
    repeat (300) step();
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_dout_hold", {20'd0, dout}, 32'h000);
    frame(12'h456, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
